multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle MIPS control unit: a Moore state machine that sequences each instruction over 3–5+ cycles and drives the shared-ALU / single-memory multi-cycle datapath. Successor to the single-cycle opcode decoder; it adds per-state sequencing, a memory ready handshake with optional timeout, mode parameters that enable or disable instruction classes, and illegal-opcode reporting. Sits between the instruction register's opcode field and the multi-cycle datapath muxes, register file and unified memory.

## Interface
- ENABLE_ADDI, default 1: 1 = addi (0x08) is legal; 0 = treated as illegal.
- ENABLE_JUMP, default 1: 1 = j (0x02) is legal; 0 = treated as illegal.
- MEM_TIMEOUT, default 0: 0 = wait forever for mem_ready; N>0 = abort the access after N cycles without ready.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  6  instruction-register bits 31:26; sampled in DECODE only.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  instruction-register load.
- mem_2_reg  out  1  write-back source: 0 ALUOut, 1 MDR.
- reg_dst  out  1  destination: 0 rt, 1 rd.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0 PC, 1 register A.
- alu_src_b  out  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
- alu_op  out  2  00 add, 01 subtract, 10 decode funct field.
- illegal_op  out  1  one-cycle pulse: unsupported opcode decoded.
- mem_err  out  1  one-cycle pulse: memory timeout.
- instr_done  out  1  one-cycle pulse in the last state of each completed instruction.
- state  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11.
- Any output not listed for a state is 0. No output is ever driven to x.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready. Advance to DECODE on mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - opcode 0x00 goes to EXEC.
  - 0x23 and 0x2B go to MEM_ADDR.
  - 0x04 goes to BRANCH.
  - 0x02 goes to JUMP if ENABLE_JUMP.
  - 0x08 goes to ADDI_EX if ENABLE_ADDI.
  - Anything else: illegal_op=1, go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_RD for 0x23, otherwise MEM_WR. The opcode is held stable by the IR.
- MEM_RD: mem_read=1, i_or_d=1; advance to MEM_WB on mem_ready.
- MEM_WB: reg_dst=0, mem_2_reg=1, reg_write=1, instr_done=1; go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1; instr_done=mem_ready; go to FETCH on mem_ready.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; go to R_WB.
- R_WB: reg_dst=1, reg_write=1, instr_done=1; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1; go to FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1; go to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; go to ADDI_WB.
- ADDI_WB: reg_dst=0, reg_write=1, instr_done=1; go to FETCH.
- Timeout (MEM_TIMEOUT>0 only):
  - A wait counter of width clog2(MEM_TIMEOUT+1) counts cycles spent in FETCH, MEM_RD or MEM_WR with mem_ready low.
  - The counter clears on any state change.
  - In the cycle where the count equals MEM_TIMEOUT and mem_ready is still low: mem_err=1, no IR/PC/register write, next state FETCH. A fetch therefore retries the same PC.
  - mem_ready high in that same cycle wins: the access completes normally and mem_err stays 0.
  - With MEM_TIMEOUT=0 the counter logic is absent and mem_err is tied 0.

## Timing
- Reset: while rst=1, the state register loads FETCH and the counter clears. All outputs are forced to 0 and state reads 0.
- The first fetch strobe appears in the first cycle after rst falls.
- Outputs are pure functions of state, plus mem_ready for ir_write/pc_write/instr_done/mem_err. They are valid in the same cycle.
- Cycle counts with zero-wait memory (mem_ready tied 1):
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each mem_ready-low cycle in a memory state adds one cycle.
- rst asserted mid-instruction aborts it at the next edge. No pulse outputs fire in the reset cycle.

## Test plan
- Reset, then mem_ready=1 and opcode=0x00: state sequence 0,1,6,7,0. reg_dst=1 and reg_write=1 only in state 7; instr_done pulses once.
- opcode=0x23 with mem_ready low for 2 cycles in MEM_RD: sequence 0,1,2,3,3,3,4. mem_2_reg=1 and reg_write=1 in state 4; total 7 cycles.
- opcode=0x2B: mem_write=1 and i_or_d=1 in state 5 only; reg_write stays 0 throughout.
- opcode=0x3F, then opcode=0x02 with ENABLE_JUMP=0: illegal_op pulses in DECODE each time and the next state is FETCH. With ENABLE_JUMP=1, opcode 0x02 reaches state 9 with pc_write=1, pc_src=10.
- MEM_TIMEOUT=3, mem_ready held 0 in FETCH: mem_err pulses on the 4th FETCH cycle, ir_write stays 0, and FETCH restarts. A second run with mem_ready=1 on that same cycle advances to DECODE with no mem_err.
- rst pulsed for 1 cycle while in state 3: all outputs are 0 in that cycle and the state is 0 on the next cycle.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle control FSM and its datapath: opcode/ready in, mux selects and strobes out.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_unit_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_2_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       mem_err;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal_op, mem_err, instr_done, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal_op, mem_err, instr_done, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM; outputs valid in the same cycle as the state (3-5 cycles per instruction at zero wait).
// Memory backpressure via mem_ready stalls FETCH/MEM_RD/MEM_WR; optional MEM_TIMEOUT aborts a stalled access back to FETCH.
module multicycle_control_unit #(
    parameter int ENABLE_ADDI = 1,
    parameter int ENABLE_JUMP = 1,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_unit_if.master   ctl
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_2_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
        logic       mem_err;
        logic       instr_done;
    } ctl_word_t;

    state_t    state_q;
    state_t    state_d;
    ctl_word_t cw;
    ctl_word_t cw_out;
    logic      timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_tmo
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
            logic [CW-1:0] wait_cnt;
            logic          waiting;

            assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                             && !ctl.mem_ready;
            assign timeout = waiting && (wait_cnt == LIMIT);

            // A FETCH timeout stays in FETCH, so it must clear the count explicitly.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wait_cnt <= '0;
                end else if ((state_d != state_q) || timeout) begin
                    wait_cnt <= '0;
                end else if (waiting) begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
        end else begin : g_no_tmo
            assign timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cw      = '0;
        case (state_q)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = 2'b01;
                cw.ir_write  = ctl.mem_ready;
                cw.pc_write  = ctl.mem_ready;
                if (ctl.mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    cw.mem_err = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                cw.alu_src_b = 2'b11;
                case (ctl.opcode)
                    6'h00:        state_d = S_EXEC;
                    6'h23, 6'h2B: state_d = S_MEM_ADDR;
                    6'h04:        state_d = S_BRANCH;
                    6'h02: begin
                        if (ENABLE_JUMP != 0) begin
                            state_d = S_JUMP;
                        end else begin
                            cw.illegal_op = 1'b1;
                            state_d       = S_FETCH;
                        end
                    end
                    6'h08: begin
                        if (ENABLE_ADDI != 0) begin
                            state_d = S_ADDI_EX;
                        end else begin
                            cw.illegal_op = 1'b1;
                            state_d       = S_FETCH;
                        end
                    end
                    default: begin
                        cw.illegal_op = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = 2'b10;
                state_d      = (ctl.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                cw.mem_read = 1'b1;
                cw.i_or_d   = 1'b1;
                if (ctl.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    cw.mem_err = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM_WB: begin
                cw.mem_2_reg  = 1'b1;
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_WR: begin
                cw.mem_write  = 1'b1;
                cw.i_or_d     = 1'b1;
                cw.instr_done = ctl.mem_ready;
                if (ctl.mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    cw.mem_err = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = 2'b10;
                state_d      = S_R_WB;
            end
            S_R_WB: begin
                cw.reg_dst    = 1'b1;
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_op        = 2'b01;
                cw.pc_write_cond = 1'b1;
                cw.pc_src        = 2'b01;
                cw.instr_done    = 1'b1;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                cw.pc_write   = 1'b1;
                cw.pc_src     = 2'b10;
                cw.instr_done = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDI_EX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = 2'b10;
                state_d      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks everything combinationally so no strobe or pulse leaks in the reset cycle.
    assign cw_out = rst ? '0 : cw;

    assign ctl.pc_write      = cw_out.pc_write;
    assign ctl.pc_write_cond = cw_out.pc_write_cond;
    assign ctl.pc_src        = cw_out.pc_src;
    assign ctl.i_or_d        = cw_out.i_or_d;
    assign ctl.mem_read      = cw_out.mem_read;
    assign ctl.mem_write     = cw_out.mem_write;
    assign ctl.ir_write      = cw_out.ir_write;
    assign ctl.mem_2_reg     = cw_out.mem_2_reg;
    assign ctl.reg_dst       = cw_out.reg_dst;
    assign ctl.reg_write     = cw_out.reg_write;
    assign ctl.alu_src_a     = cw_out.alu_src_a;
    assign ctl.alu_src_b     = cw_out.alu_src_b;
    assign ctl.alu_op        = cw_out.alu_op;
    assign ctl.illegal_op    = cw_out.illegal_op;
    assign ctl.mem_err       = cw_out.mem_err;
    assign ctl.instr_done    = cw_out.instr_done;
    assign ctl.state         = rst ? 4'd0 : state_q;

endmodule
